chunked_subtractor: RTL and testbench

- Multi-cycle WIDTH-bit subtractor: computes diff = a - b - bin, one CHUNK_W-bit slice per clock, LSB slice first.
- The borrow is registered between slices.
- Inverse-operation companion to the team's chained ripple adder datapath.
- Sits in the ALU path where area matters more than latency; start/busy/done handshake to the controller.

---
 rtl/chunked_subtractor.sv | 153 +++++++++++++++
 tb/tb_chunked_subtractor.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/chunked_subtractor.sv
// Multi-cycle WIDTH-bit subtractor: diff = a - b - bin, one CHUNK_W slice per clock, LSB first.
// Define ADD_MODE_EN to add an op input selecting a + b + bin (bout then reports carry out).
module chunked_subtractor #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned CHUNK_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
`ifdef ADD_MODE_EN
   input  logic             op,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);

   localparam int unsigned N     = WIDTH / CHUNK_W;
   localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

   typedef enum logic {IDLE, RUN} state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic               bor_q, bor_d;
   logic               a_msb_q, a_msb_d;
   logic               b_msb_q, b_msb_d;
   logic               op_q, op_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [WIDTH-1:0]   diff_q, diff_d;
   logic               bout_q, bout_d;
   logic               ovf_q, ovf_d;

   logic                       op_in_c;
   logic [WIDTH-1:0]           b_eff_c;
   logic [CHUNK_W:0]           slice_c;
   logic [WIDTH+CHUNK_W-1:0]   res_cat_c;
   logic [WIDTH-1:0]           res_shift_c;

`ifdef ADD_MODE_EN
   assign op_in_c = op;
`else
   assign op_in_c = 1'b0;
`endif

   // Addition reuses the subtractor: a + b + c == a - ~b - ~c, with inverted borrow sense.
   assign b_eff_c = op_in_c ? ~b : b;

   assign slice_c = {1'b0, a_q[CHUNK_W-1:0]} - {1'b0, b_q[CHUNK_W-1:0]}
                    - (CHUNK_W+1)'(bor_q);

   // New slice enters at the top; after N slices the result is fully aligned.
   assign res_cat_c   = {slice_c[CHUNK_W-1:0], res_q};
   assign res_shift_c = res_cat_c[WIDTH+CHUNK_W-1:CHUNK_W];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      bor_d   = bor_q;
      a_msb_d = a_msb_q;
      b_msb_d = b_msb_q;
      op_d    = op_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      diff_d  = diff_q;
      bout_d  = bout_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b_eff_c;
               bor_d   = bin ^ op_in_c;
               a_msb_d = a[WIDTH-1];
               b_msb_d = b_eff_c[WIDTH-1];
               op_d    = op_in_c;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            a_d   = a_q >> CHUNK_W;
            b_d   = b_q >> CHUNK_W;
            bor_d = slice_c[CHUNK_W];
            res_d = res_shift_c;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(N - 1)) begin
               diff_d  = res_shift_c;
               bout_d  = slice_c[CHUNK_W] ^ op_q;
               ovf_d   = (a_msb_q != b_msb_q) && (slice_c[CHUNK_W-1] != a_msb_q);
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         bor_q   <= 1'b0;
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         op_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         bor_q   <= bor_d;
         a_msb_q <= a_msb_d;
         b_msb_q <= b_msb_d;
         op_q    <= op_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign diff = diff_q;
   assign bout = bout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_chunked_subtractor.sv
// Self-checking bench for chunked_subtractor: arithmetic reference model plus directed literal checks.
module tb_chunked_subtractor;

   localparam int unsigned WIDTH   = 32;
   localparam int unsigned CHUNK_W = 16;
   localparam int unsigned N       = WIDTH / CHUNK_W;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start = 1'b0;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             bin = 1'b0;
   logic             op = 1'b0;
   logic             busy, done, bout, ovf;
   logic [WIDTH-1:0] diff;

   int checks = 0;
   int errors = 0;
   int done_seen = 0;

   chunked_subtractor #(.WIDTH(WIDTH), .CHUNK_W(CHUNK_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
`ifdef ADD_MODE_EN
      .op    (op),
`endif
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;

   // Plain integer arithmetic: returns {bout, ovf, diff}.
   function automatic logic [WIDTH+1:0] model_op(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                                 input logic mbin, input logic mop);
      longint ua, ub, sa, sb, ur, sr;
      logic   mbo, mov;
      logic [WIDTH-1:0] md;
      ua = longint'(ma);
      ub = longint'(mb);
      sa = longint'($signed(ma));
      sb = longint'($signed(mb));
      if (mop) begin
         ur  = ua + ub + longint'(mbin);
         sr  = sa + sb + longint'(mbin);
         mbo = (ur > 64'sd4294967295);
      end else begin
         ur  = ua - ub - longint'(mbin);
         sr  = sa - sb - longint'(mbin);
         mbo = (ur < 0);
      end
      mov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      md  = ur[WIDTH-1:0];
      return {mbo, mov, md};
   endfunction

   int               m_rem = 0;
   logic             m_busy = 1'b0, m_done = 1'b0, m_bout = 1'b0, m_ovf = 1'b0;
   logic [WIDTH-1:0] m_diff = '0;
   logic [WIDTH+1:0] m_pend = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_rem  <= 0;
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_diff <= '0;
         m_bout <= 1'b0;
         m_ovf  <= 1'b0;
      end else begin
         m_done <= 1'b0;
         if (m_rem > 1) begin
            m_rem <= m_rem - 1;
         end else if (m_rem == 1) begin
            m_rem  <= 0;
            m_done <= 1'b1;
            m_busy <= 1'b0;
            m_bout <= m_pend[WIDTH+1];
            m_ovf  <= m_pend[WIDTH];
            m_diff <= m_pend[WIDTH-1:0];
         end else if (start) begin
            m_pend <= model_op(a, b, bin, op);
            m_rem  <= N;
            m_busy <= 1'b1;
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         if (done === 1'b1) done_seen++;
         check("busy", 64'(busy), 64'(m_busy));
         check("done", 64'(done), 64'(m_done));
         check("diff", 64'(diff), 64'(m_diff));
         check("bout", 64'(bout), 64'(m_bout));
         check("ovf",  64'(ovf),  64'(m_ovf));
      end
   end

   // Issue one operation from a negedge, wait for done, and compare against literal expectations.
   task automatic run_op(input string name, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                         input logic tbin, input logic top, input logic [WIDTH-1:0] ediff,
                         input logic ebout, input logic eovf);
      int busy_cycles;
      int d0;
      bit got;
      busy_cycles = 0;
      got = 0;
      d0 = done_seen;
      a = ta; b = tb; bin = tbin; op = top; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a = ~ta; b = ~tb; bin = ~tbin;
      for (int i = 0; i < 10; i++) begin
         if (busy === 1'b1) busy_cycles++;
         if (done === 1'b1) begin
            got = 1;
            break;
         end
         @(negedge clk);
      end
      check({name, "_timeout"}, 64'(got), 64'(1));
      check({name, "_busy_cycles"}, 64'(busy_cycles), 64'(N));
      check({name, "_diff"}, 64'(diff), 64'(ediff));
      check({name, "_bout"}, 64'(bout), 64'(ebout));
      check({name, "_ovf"},  64'(ovf),  64'(eovf));
      @(negedge clk);
      check({name, "_done_once"}, 64'(done_seen - d0), 64'(1));
      check({name, "_done_low"}, 64'(done), 64'(0));
   endtask

   initial begin
      int d0;
      bit got;
      rst_n = 1'b0;
      @(negedge clk);
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_diff", 64'(diff), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run_op("basic",     32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 32'h0000_0002, 1'b0, 1'b0);
      run_op("underflow", 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
      run_op("sovf",      32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
      run_op("xslice",    32'h0001_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_FFFE, 1'b0, 1'b0);
      run_op("neg_ovf",   32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h8000_0000, 1'b1, 1'b1);
      run_op("eq_bin",    32'h0000_1234, 32'h0000_1234, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
      run_op("hi_slice",  32'h1234_5678, 32'h0234_5679, 1'b0, 1'b0, 32'h0FFF_FFFF, 1'b0, 1'b0);
`ifdef ADD_MODE_EN
      run_op("add_wrap",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
      run_op("add_ovf",   32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b1, 32'h8000_0000, 1'b0, 1'b1);
      run_op("add_sub0",  32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 32'h0000_0002, 1'b0, 1'b0);
`endif

      // Start while busy is ignored.
      d0 = done_seen;
      a = 32'd9; b = 32'd4; bin = 1'b0; op = 1'b0; start = 1'b1;
      @(negedge clk);
      a = 32'd1; b = 32'd1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      check("busy_ign_done_cnt", 64'(done_seen - d0), 64'(1));
      check("busy_ign_diff", 64'(diff), 64'h5);

      // Start in the done cycle is accepted; each op pulses done once.
      d0 = done_seen;
      a = 32'd100; b = 32'd1; bin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      got = 0;
      for (int i = 0; i < 10; i++) begin
         if (done === 1'b1) begin
            got = 1;
            break;
         end
         @(negedge clk);
      end
      check("b2b_first_timeout", 64'(got), 64'(1));
      check("b2b_first_diff", 64'(diff), 64'd99);
      a = 32'd7; b = 32'd8; bin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("b2b_accepted_busy", 64'(busy), 64'(1));
      repeat (4) @(negedge clk);
      check("b2b_done_cnt", 64'(done_seen - d0), 64'(2));
      check("b2b_second_diff", 64'(diff), 64'hFFFF_FFFF);
      check("b2b_second_bout", 64'(bout), 64'(1));

      // Reset mid-operation aborts without a done.
      d0 = done_seen;
      a = 32'd50; b = 32'd20; bin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rst_mid_busy", 64'(busy), 64'(0));
      check("rst_mid_diff", 64'(diff), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("rst_mid_no_done", 64'(done_seen - d0), 64'(0));
      check("rst_mid_diff_after", 64'(diff), 64'(0));

      // A few pseudo-random operations checked by the model alone.
      for (int i = 0; i < 20; i++) begin
         a = $urandom; b = $urandom; bin = 1'($urandom_range(1));
`ifdef ADD_MODE_EN
         op = 1'($urandom_range(1));
`endif
         start = 1'b1;
         @(negedge clk);
         start = 1'($urandom_range(1));
         a = $urandom; b = $urandom;
         repeat (N + 1) @(negedge clk);
         start = 1'b0;
      end
      repeat (5) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
